// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB memory arbiter slice.
//   ORB_DW / ORB_AW : orbit word and telemetry memory address widths
//   arb_state_e     : arbiter phase (no owner, owner active, quiet turnaround)
package lcb_pkg;

    localparam int unsigned ORB_DW = 12;
    localparam int unsigned ORB_AW = 10;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index where the upward (wrapping) search starts
//   gnt   : one-hot winner, zero when no request is set
//   idx   : binary index of the winner, zero when no request is set
//   valid : at least one request was set
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    logic [PW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = PW'((32'(ptr) + k) % N);
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/lcb_mem_arbiter.sv
// Round-robin arbiter sharing the write/read-modify port of the inactive telemetry bank
// between N LCB receive channels.
//   clk, reset        : single clock, synchronous active-high reset
//   busy              : per-requester burst request
//   wrdOut/wrdAddr/wren, oldWrdAddr/oldRdEn : per-requester port signals (packed slices)
//   oldWrd            : per-requester read data, only the owner's slice is live
//   commOldWrd        : read data from the bank mux
//   comm*             : common port towards the bank mux, zero when nobody owns it
//   iSwitch           : bank select; edges during a grant are counted, edges while idle
//                       delay the next grant by one cycle
//   grant             : registered one-hot owner
//   oTimeout          : one-cycle pulse when a grant is forcibly revoked
//   oCollisions       : saturating count of bank switches seen during grants
module lcb_mem_arbiter
    import lcb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned AW       = ORB_AW,
    parameter int unsigned DW       = ORB_DW,
    parameter int unsigned HOLD_MAX = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    busy,
    input  logic [N*DW-1:0] wrdOut,
    input  logic [N*AW-1:0] wrdAddr,
    input  logic [N-1:0]    wren,
    input  logic [N*AW-1:0] oldWrdAddr,
    input  logic [N-1:0]    oldRdEn,
    output logic [N*DW-1:0] oldWrd,
    input  logic [DW-1:0]   commOldWrd,
    output logic [DW-1:0]   commWrdOut,
    output logic [AW-1:0]   commWrdAddr,
    output logic            commWren,
    output logic [AW-1:0]   commOldWrdAddr,
    output logic            commOldRdEn,
    input  logic            iSwitch,
    output logic [N-1:0]    grant,
    output logic            oTimeout,
    output logic [7:0]      oCollisions
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(HOLD_MAX);

    arb_state_e    state;
    logic [PW-1:0] owner;
    logic [PW-1:0] ptr;
    logic [N-1:0]  lock;
    logic [CW-1:0] hold_cnt;
    logic          sw_prev;
    logic          sw_edge;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;
    logic [PW-1:0] ptr_next;

    assign sw_edge  = iSwitch ^ sw_prev;
    assign ptr_next = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;

    // Locked requesters (previous timeout, busy never dropped) are hidden from arbitration.
    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (busy & ~lock),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            ptr         <= '0;
            lock        <= '0;
            hold_cnt    <= '0;
            sw_prev     <= 1'b0;
            oTimeout    <= 1'b0;
            oCollisions <= '0;
        end else begin
            sw_prev  <= iSwitch;
            oTimeout <= 1'b0;
            // A lock lives only until the requester finally drops busy.
            lock     <= lock & busy;
            unique case (state)
                IDLE: begin
                    if (pick_valid && !sw_edge) begin
                        state    <= GRANT;
                        grant    <= pick_gnt;
                        owner    <= pick_idx;
                        ptr      <= ptr_next;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (sw_edge && oCollisions != 8'hFF) begin
                        oCollisions <= oCollisions + 8'd1;
                    end
                    if (!busy[owner]) begin
                        state <= RELEASE;
                        grant <= '0;
                    end else if (hold_cnt == CW'(HOLD_MAX - 1)) begin
                        state       <= RELEASE;
                        grant       <= '0;
                        oTimeout    <= 1'b1;
                        lock[owner] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data path is a pure mux on the registered grant: no added latency, all zero when idle.
    always_comb begin
        commWrdOut     = '0;
        commWrdAddr    = '0;
        commWren       = 1'b0;
        commOldWrdAddr = '0;
        commOldRdEn    = 1'b0;
        oldWrd         = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                commWrdOut            = wrdOut[i*DW +: DW];
                commWrdAddr           = wrdAddr[i*AW +: AW];
                commWren              = wren[i];
                commOldWrdAddr        = oldWrdAddr[i*AW +: AW];
                commOldRdEn           = oldRdEn[i];
                oldWrd[i*DW +: DW]    = commOldWrd;
            end
        end
    end

endmodule

// File: tb/tb_lcb_mem_arbiter.sv
// Bench for lcb_mem_arbiter: directed scenarios plus a randomized run against a
// behavioural model (owner / gap / hold / pointer / locks / collision count).
module tb_lcb_mem_arbiter;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 12;
    localparam int HOLD = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    busy;
    logic [N*DW-1:0] wrdOut;
    logic [N*AW-1:0] wrdAddr;
    logic [N-1:0]    wren;
    logic [N*AW-1:0] oldWrdAddr;
    logic [N-1:0]    oldRdEn;
    logic [N*DW-1:0] oldWrd;
    logic [DW-1:0]   commOldWrd;
    logic [DW-1:0]   commWrdOut;
    logic [AW-1:0]   commWrdAddr;
    logic            commWren;
    logic [AW-1:0]   commOldWrdAddr;
    logic            commOldRdEn;
    logic            iSwitch;
    logic [N-1:0]    grant;
    logic            oTimeout;
    logic [7:0]      oCollisions;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int       m_owner = -1;
    int       m_gap   = 0;
    int       m_hold  = 0;
    int       m_ptr   = 0;
    int       m_coll  = 0;
    bit       m_timeout = 0;
    bit [3:0] m_lock  = '0;
    bit       m_sw_prev = 0;

    lcb_mem_arbiter #(
        .N        (N),
        .AW       (AW),
        .DW       (DW),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .busy           (busy),
        .wrdOut         (wrdOut),
        .wrdAddr        (wrdAddr),
        .wren           (wren),
        .oldWrdAddr     (oldWrdAddr),
        .oldRdEn        (oldRdEn),
        .oldWrd         (oldWrd),
        .commOldWrd     (commOldWrd),
        .commWrdOut     (commWrdOut),
        .commWrdAddr    (commWrdAddr),
        .commWren       (commWren),
        .commOldWrdAddr (commOldWrdAddr),
        .commOldRdEn    (commOldRdEn),
        .iSwitch        (iSwitch),
        .grant          (grant),
        .oTimeout       (oTimeout),
        .oCollisions    (oCollisions)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit [3:0] old_lock;
        bit       sw_edge;
        int       w;
        if (reset) begin
            m_owner = -1; m_gap = 0; m_hold = 0; m_ptr = 0;
            m_coll = 0; m_timeout = 0; m_lock = '0; m_sw_prev = 0;
            return;
        end
        sw_edge   = (iSwitch != m_sw_prev);
        m_sw_prev = iSwitch;
        old_lock  = m_lock;
        m_lock    = m_lock & busy;
        m_timeout = 0;
        if (m_owner >= 0) begin
            if (sw_edge && m_coll < 255) m_coll++;
            if (!busy[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (m_hold == HOLD - 1) begin
                m_lock[m_owner] = 1'b1; m_timeout = 1; m_owner = -1; m_gap = 1;
            end else begin
                m_hold++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (!sw_edge) begin
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (busy[w] && !old_lock[w]) begin
                    m_owner = w; m_hold = 0; m_ptr = (w + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; busy = '0; wren = '0; oldRdEn = '0; iSwitch = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int oh2idx(logic [3:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; busy = 4'hF; wren = 4'hF; oldRdEn = 4'hF; iSwitch = 1'b0;
        wrdOut = '1; wrdAddr = '1; oldWrdAddr = '1; commOldWrd = 12'hFFF;
        tick(); tick();
        n_checks++;
        if (grant !== 4'b0) begin
            n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant);
        end
        n_checks++;
        if ({oTimeout, oCollisions} !== 9'h0) begin
            n_fail++; $display("FAIL reset_status got=%b/%h exp=0/00", oTimeout, oCollisions);
        end
        n_checks++;
        if ({commWren, commWrdAddr, commWrdOut, commOldRdEn, commOldWrdAddr} !== '0) begin
            n_fail++; $display("FAIL reset_comm got=%b %h %h %b %h exp=zeros",
                               commWren, commWrdAddr, commWrdOut, commOldRdEn, commOldWrdAddr);
        end
        n_checks++;
        if (oldWrd !== '0) begin
            n_fail++; $display("FAIL reset_oldwrd got=%h exp=0", oldWrd);
        end
        busy = '0; wren = '0; oldRdEn = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_requester();
        bit held_ok;
        do_reset();
        busy = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant got=%b exp=0100", grant);
        end
        wrdAddr[2*AW +: AW] = 10'h155; wrdOut[2*DW +: DW] = 12'hABC; wren[2] = 1'b1;
        wrdAddr[0 +: AW] = 10'h3FF; wren[0] = 1'b1;
        #1;
        n_checks++;
        if ({commWren, commWrdAddr, commWrdOut} !== {1'b1, 10'h155, 12'hABC}) begin
            n_fail++; $display("FAIL single_route got=%b %h %h exp=1 155 abc",
                               commWren, commWrdAddr, commWrdOut);
        end
        wren[2] = 1'b0;
        #1;
        n_checks++;
        if (commWren !== 1'b0) begin
            n_fail++; $display("FAIL single_nonowner_wren got=%b exp=0", commWren);
        end
        held_ok = 1;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (grant !== 4'b0100) held_ok = 0;
        end
        n_checks++;
        if (!held_ok) begin
            n_fail++; $display("FAIL single_hold got=0 exp=1 (grant dropped during burst)");
        end
        busy = '0; wren = '0;
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL single_release got=%b exp=0000", grant);
        end
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int order[$];
        int prev, len, gap, cur;
        do_reset();
        busy = 4'hF; prev = -1; len = 0; gap = 0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            tick();
            busy = 4'hF;
            if (grant != 0) begin
                cur = oh2idx(grant);
                if (prev < 0 || gap > 0) begin
                    if (prev >= 0) begin
                        n_checks++;
                        if (gap != 2) begin
                            n_fail++; $display("FAIL rr_gap got=%0d exp=2", gap);
                        end
                    end
                    order.push_back(cur); len = 0; gap = 0; prev = cur;
                end
                len++;
                if (len == 5) busy[cur] = 1'b0;
            end else begin
                gap++;
            end
        end
        n_checks++;
        if (order.size() != 5) begin
            n_fail++; $display("FAIL rr_count got=%0d exp=5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (order[k] != exp_order[k]) begin
                    n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k],
                                       exp_order[k]);
                end
            end
        end
        busy = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_stuck_requester();
        int  gcnt;
        bit  saw, idle_ok;
        do_reset();
        busy = 4'b0010; gcnt = 0; saw = 0;
        for (int c = 0; c < 60 && !saw; c++) begin
            tick();
            if (c == 3) busy[3] = 1'b1;
            if (grant === 4'b0010) gcnt++;
            if (oTimeout === 1'b1) saw = 1;
        end
        n_checks++;
        if (!saw || gcnt != HOLD) begin
            n_fail++; $display("FAIL stuck_timeout got=seen%0d/%0d cycles exp=seen1/%0d cycles",
                               saw, gcnt, HOLD);
        end
        tick();
        n_checks++;
        if ({oTimeout, grant} !== 5'b0_0000) begin
            n_fail++; $display("FAIL stuck_pulse got=%b/%b exp=0/0000", oTimeout, grant);
        end
        tick();
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++; $display("FAIL stuck_next got=%b exp=1000", grant);
        end
        tick(); tick();
        busy[3] = 1'b0;
        tick();
        idle_ok = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (grant !== 4'b0000) idle_ok = 0;
        end
        n_checks++;
        if (!idle_ok) begin
            n_fail++; $display("FAIL stuck_locked got=regrant exp=no grant while locked");
        end
        busy[1] = 1'b0;
        tick();
        busy[1] = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++; $display("FAIL stuck_unlock got=%b exp=0010", grant);
        end
        busy = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_switch();
        int toggles, len;
        do_reset();
        busy = 4'b0001; iSwitch = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL sw_idle_suppress got=%b exp=0000", grant);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL sw_idle_resume got=%b exp=0001", grant);
        end
        iSwitch = 1'b0; tick();
        iSwitch = 1'b1; tick();
        n_checks++;
        if ({grant, oCollisions} !== {4'b0001, 8'd2}) begin
            n_fail++; $display("FAIL sw_two got=%b/%0d exp=0001/2", grant, oCollisions);
        end
        toggles = 0; len = 2;
        for (int c = 0; c < 2000 && toggles < 300; c++) begin
            tick();
            if (grant != 0) begin
                len++;
                iSwitch = ~iSwitch;
                toggles++;
                if (len >= 8) begin busy = '0; len = 0; end
            end else begin
                busy = 4'b0001;
            end
        end
        tick();
        n_checks++;
        if (toggles < 300 || oCollisions !== 8'hFF) begin
            n_fail++; $display("FAIL sw_saturate got=%0d (toggles %0d) exp=255", oCollisions,
                               toggles);
        end
        busy = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_read_and_reset();
        do_reset();
        busy = 4'b0001;
        tick();
        commOldWrd = 12'h5A5; oldRdEn = 4'b0011;
        oldWrdAddr[0 +: AW] = 10'h2AA; oldWrdAddr[AW +: AW] = 10'h111;
        #1;
        n_checks++;
        if (oldWrd !== 48'h000_000_000_5A5) begin
            n_fail++; $display("FAIL read_route got=%h exp=0000000005a5", oldWrd);
        end
        n_checks++;
        if ({commOldRdEn, commOldWrdAddr} !== {1'b1, 10'h2AA}) begin
            n_fail++; $display("FAIL read_addr got=%b/%h exp=1/2aa", commOldRdEn, commOldWrdAddr);
        end
        busy = '0;
        tick(); tick();
        busy = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL rst_pre got=%b exp=0100", grant);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({grant, oTimeout, oCollisions, commOldRdEn, commWren, oldWrd, commWrdOut} !== '0) begin
            n_fail++; $display("FAIL rst_mid got=%b %b %h %b %b %h %h exp=zeros", grant, oTimeout,
                               oCollisions, commOldRdEn, commWren, oldWrd, commWrdOut);
        end
        reset = 1'b0; busy = 4'hF;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL rst_ptr got=%b exp=0001", grant);
        end
        busy = '0; oldRdEn = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [3:0]      eg;
        logic [AW+DW:0]  ew;
        logic [AW:0]     er;
        logic [N*DW-1:0] eo;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(11) == 0) busy[i] = ~busy[i];
            wren       = 4'($urandom());
            oldRdEn    = 4'($urandom());
            wrdOut     = {16'($urandom()), 32'($urandom())};
            wrdAddr    = {8'($urandom()), 32'($urandom())};
            oldWrdAddr = {8'($urandom()), 32'($urandom())};
            commOldWrd = 12'($urandom());
            if ($urandom_range(19) == 0) iSwitch = ~iSwitch;
            reset = ($urandom_range(499) == 0);
            tick();
            eg = m_grant();
            ew = '0; er = '0; eo = '0;
            if (m_owner >= 0) begin
                ew = {wren[m_owner], wrdAddr[m_owner*AW +: AW], wrdOut[m_owner*DW +: DW]};
                er = {oldRdEn[m_owner], oldWrdAddr[m_owner*AW +: AW]};
                eo[m_owner*DW +: DW] = commOldWrd;
            end
            n_checks++;
            if (grant !== eg) begin
                n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant, eg);
            end
            n_checks++;
            if (oTimeout !== m_timeout) begin
                n_fail++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", c, oTimeout, m_timeout);
            end
            n_checks++;
            if (oCollisions !== 8'(m_coll)) begin
                n_fail++; $display("FAIL rnd_coll cyc=%0d got=%0d exp=%0d", c, oCollisions, m_coll);
            end
            n_checks++;
            if ({commWren, commWrdAddr, commWrdOut} !== ew) begin
                n_fail++; $display("FAIL rnd_write cyc=%0d got=%h exp=%h", c,
                                   {commWren, commWrdAddr, commWrdOut}, ew);
            end
            n_checks++;
            if ({commOldRdEn, commOldWrdAddr} !== er) begin
                n_fail++; $display("FAIL rnd_read cyc=%0d got=%h exp=%h", c,
                                   {commOldRdEn, commOldWrdAddr}, er);
            end
            n_checks++;
            if (oldWrd !== eo) begin
                n_fail++; $display("FAIL rnd_oldwrd cyc=%0d got=%h exp=%h", c, oldWrd, eo);
            end
        end
        reset = 1'b0; busy = '0;
        tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1; busy = '0; wren = '0; oldRdEn = '0; iSwitch = 1'b0;
        wrdOut = '0; wrdAddr = '0; oldWrdAddr = '0; commOldWrd = '0;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_stuck_requester();
        test_switch();
        test_read_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no finish exp=finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
